// File: rtl/generic_multi_table_regs_pkg.sv
// Shared constants, state encoding and helpers for the multi-table register window.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package generic_multi_table_regs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Control register offsets, relative to the first register after the ENTRY words
  localparam int ADDR_OFS      = 0;
  localparam int CMD_OFS       = 1;
  localparam int STATUS_OFS    = 2;
  localparam int NUM_CTRL_REGS = 3;

  // CMD / STATUS field positions
  localparam int CMD_OP_BIT       = 31;
  localparam int SEL_W            = 8;
  localparam int STAT_TIMEOUT_BIT = 1;
  localparam int STAT_BAD_SEL_BIT = 2;
  localparam int STAT_SEL_LSB     = 8;

  function automatic int ceildiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Ceiling log2: number of bits needed to index v items
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/generic_multi_table_regs_table_req_timer.sv
// Tracks one outstanding table request and counts cycles until ack or timeout.
// Latency: active rises the cycle after start; ack/timeout clear it the next cycle.
// Backpressure: none; a timeout of 0 waits forever for the ack.
module generic_multi_table_regs_table_req_timer
  import generic_multi_table_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic active,
  output logic timeout
);

  localparam int CW   = (log2(TIMEOUT_CYCLES + 1) < 1) ? 1 : log2(TIMEOUT_CYCLES + 1);
  localparam int LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CW-1:0] cnt;

  // Fires in the last cycle the request is allowed to stay high; ack wins a tie
  assign timeout = active && !ack && (TIMEOUT_CYCLES != 0) && (cnt == CW'(LAST));

  // Request lifetime and elapsed-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      if (ack || timeout) active <= 1'b0;
      else                cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/generic_multi_table_regs.sv
// Register-ring window giving indirect read/write access to external tables.
// Latency: passthrough/read hit 1 cycle; writes ack 2 cycles after accept, commands after table ack.
// Backpressure: ring inputs ignored while a write/command is in flight; upstream holds until acked.
module generic_multi_table_regs
  import generic_multi_table_regs_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int NUM_TABLES        = 4,
  parameter int TABLE_ENTRY_WIDTH = 72,
  parameter int TABLE_ADDR_WIDTH  = 10,
  parameter int TIMEOUT_CYCLES    = 1023,
  parameter int REG_START_ADDR    = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      reg_req_in,
  input  logic                                      reg_ack_in,
  input  logic                                      reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]            reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]           reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]              reg_src_in,
  output logic                                      reg_req_out,
  output logic                                      reg_ack_out,
  output logic                                      reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]            reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]           reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]              reg_src_out,
  output logic [NUM_TABLES-1:0]                     table_rd_req,
  input  logic [NUM_TABLES-1:0]                     table_rd_ack,
  input  logic [NUM_TABLES*TABLE_ENTRY_WIDTH-1:0]   table_rd_data,
  output logic [NUM_TABLES-1:0]                     table_wr_req,
  input  logic [NUM_TABLES-1:0]                     table_wr_ack,
  output logic [TABLE_ADDR_WIDTH-1:0]               table_addr,
  output logic [TABLE_ENTRY_WIDTH-1:0]              table_wr_data
);

  localparam int AW   = `UDP_REG_ADDR_WIDTH;
  localparam int DW   = `CPCI_NF2_DATA_WIDTH;
  localparam int N    = ceildiv(TABLE_ENTRY_WIDTH, 32);
  localparam int PADW = N * 32;
  localparam int IDXW = (log2(NUM_TABLES) < 1) ? 1 : log2(NUM_TABLES);
  localparam int TAGW = AW - REG_ADDR_WIDTH;

  state_t state_q, state_d;

  logic [TABLE_ENTRY_WIDTH-1:0] entry_q;
  logic [DW-1:0]                addr_q, cmd_q;
  logic                         stat_timeout, stat_bad_sel, op_rd;
  logic [SEL_W-1:0]             last_sel;
  logic                         hold_rd_wr_L;
  logic [AW-1:0]                hold_addr;
  logic [DW-1:0]                hold_data;
  logic [UDP_REG_SRC_WIDTH-1:0] hold_src;

  logic                         tag_hit, in_range, hit, bad_sel, sel_ack;
  logic [31:0]                  local_addr, ofs;
  logic [PADW-1:0]              padded, wr_padded;
  logic [DW-1:0]                rd_word, status_word;
  logic [IDXW-1:0]              tbl_idx;
  logic [NUM_TABLES-1:0]        onehot;
  logic [TABLE_ENTRY_WIDTH-1:0] rd_slice;
  logic                         tmr_active, tmr_timeout;

  logic                         nxt_req, nxt_ack, nxt_rd_wr_L;
  logic [AW-1:0]                nxt_addr;
  logic [DW-1:0]                nxt_data;
  logic [UDP_REG_SRC_WIDTH-1:0] nxt_src;
  logic                         hold_ld, ent_wr, addr_wr, cmd_wr, issue, start, cap_rd, set_timeout;

  assign tag_hit    = (reg_addr_in[AW-1:REG_ADDR_WIDTH] == TAGW'(TAG));
  assign local_addr = 32'(reg_addr_in[REG_ADDR_WIDTH-1:0]);
  assign ofs        = local_addr - 32'(REG_START_ADDR);
  assign in_range   = (local_addr >= 32'(REG_START_ADDR)) && (ofs < 32'(N + NUM_CTRL_REGS));
  assign hit        = tag_hit && in_range;
  assign padded     = PADW'(entry_q);
  assign bad_sel    = (32'(cmd_q[SEL_W-1:0]) >= 32'(NUM_TABLES));
  assign tbl_idx    = last_sel[IDXW-1:0];
  assign onehot     = NUM_TABLES'(1) << tbl_idx;
  assign rd_slice   = table_rd_data[tbl_idx*TABLE_ENTRY_WIDTH +: TABLE_ENTRY_WIDTH];
  assign sel_ack    = tmr_active && (op_rd ? table_rd_ack[tbl_idx] : table_wr_ack[tbl_idx]);

  assign table_rd_req  = (tmr_active && op_rd)  ? onehot : '0;
  assign table_wr_req  = (tmr_active && !op_rd) ? onehot : '0;
  assign table_addr    = addr_q[TABLE_ADDR_WIDTH-1:0];
  assign table_wr_data = entry_q;

  generic_multi_table_regs_table_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ack    (sel_ack),
    .active (tmr_active),
    .timeout(tmr_timeout)
  );

  // Read-back mux and ENTRY word merge; word 0 holds the most significant bits
  always_comb begin
    status_word = '0;
    status_word[STAT_TIMEOUT_BIT]          = stat_timeout;
    status_word[STAT_BAD_SEL_BIT]          = stat_bad_sel;
    status_word[STAT_SEL_LSB +: SEL_W]     = last_sel;
    rd_word   = '0;
    wr_padded = padded;
    for (int i = 0; i < N; i++) begin
      if (ofs == 32'(i)) begin
        rd_word = padded[(N-1-i)*32 +: 32];
        wr_padded[(N-1-i)*32 +: 32] = reg_data_in;
      end
    end
    if (ofs == 32'(N + ADDR_OFS))   rd_word = addr_q;
    if (ofs == 32'(N + CMD_OFS))    rd_word = cmd_q;
    if (ofs == 32'(N + STATUS_OFS)) rd_word = status_word;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, next ring outputs and register update strobes
  always_comb begin
    state_d     = state_q;
    nxt_req     = 1'b0;
    nxt_ack     = 1'b0;
    nxt_rd_wr_L = 1'b0;
    nxt_addr    = '0;
    nxt_data    = '0;
    nxt_src     = '0;
    hold_ld     = 1'b0;
    ent_wr      = 1'b0;
    addr_wr     = 1'b0;
    cmd_wr      = 1'b0;
    issue       = 1'b0;
    start       = 1'b0;
    cap_rd      = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reg_req_in && hit) begin
          if (reg_rd_wr_L_in) begin
            nxt_req     = 1'b1;
            nxt_ack     = 1'b1;
            nxt_rd_wr_L = 1'b1;
            nxt_addr    = reg_addr_in;
            nxt_data    = rd_word;
            nxt_src     = reg_src_in;
          end else begin
            hold_ld = 1'b1;
            ent_wr  = (ofs < 32'(N));
            addr_wr = (ofs == 32'(N + ADDR_OFS));
            cmd_wr  = (ofs == 32'(N + CMD_OFS));
            state_d = cmd_wr ? ST_ISSUE : ST_DONE;
          end
        end else begin
          nxt_req     = reg_req_in;
          nxt_ack     = reg_ack_in;
          nxt_rd_wr_L = reg_rd_wr_L_in;
          nxt_addr    = reg_addr_in;
          nxt_data    = reg_data_in;
          nxt_src     = reg_src_in;
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        if (bad_sel) begin
          state_d = ST_DONE;
        end else begin
          start   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sel_ack) begin
          cap_rd  = op_rd;
          state_d = ST_DONE;
        end else if (tmr_timeout) begin
          set_timeout = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        nxt_req     = 1'b1;
        nxt_ack     = 1'b1;
        nxt_rd_wr_L = hold_rd_wr_L;
        nxt_addr    = hold_addr;
        nxt_data    = hold_data;
        nxt_src     = hold_src;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ring outputs, staging registers, status and the held request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      entry_q         <= '0;
      addr_q          <= '0;
      cmd_q           <= '0;
      stat_timeout    <= 1'b0;
      stat_bad_sel    <= 1'b0;
      last_sel        <= '0;
      op_rd           <= 1'b0;
      hold_rd_wr_L    <= 1'b0;
      hold_addr       <= '0;
      hold_data       <= '0;
      hold_src        <= '0;
    end else begin
      reg_req_out     <= nxt_req;
      reg_ack_out     <= nxt_ack;
      reg_rd_wr_L_out <= nxt_rd_wr_L;
      reg_addr_out    <= nxt_addr;
      reg_data_out    <= nxt_data;
      reg_src_out     <= nxt_src;
      if (hold_ld) begin
        hold_rd_wr_L <= reg_rd_wr_L_in;
        hold_addr    <= reg_addr_in;
        hold_data    <= reg_data_in;
        hold_src     <= reg_src_in;
      end
      if (ent_wr)      entry_q <= wr_padded[TABLE_ENTRY_WIDTH-1:0];
      else if (cap_rd) entry_q <= rd_slice;
      if (addr_wr) addr_q <= reg_data_in;
      if (cmd_wr)  cmd_q  <= reg_data_in;
      if (issue) begin
        stat_timeout <= 1'b0;
        stat_bad_sel <= bad_sel;
        last_sel     <= cmd_q[SEL_W-1:0];
        op_rd        <= cmd_q[CMD_OP_BIT];
      end
      if (set_timeout) stat_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_generic_multi_table_regs.sv
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
module tb_generic_multi_table_regs;

  localparam int AW  = `UDP_REG_ADDR_WIDTH;
  localparam int NT  = 4;
  localparam int EW  = 72;
  localparam int TAW = 10;
  localparam int TO  = 8;
  localparam int NE  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [31:0]   reg_data_in = '0;
  logic [1:0]    reg_src_in = '0;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [31:0]   reg_data_out;
  logic [1:0]    reg_src_out;
  logic [NT-1:0] table_rd_req, table_wr_req;
  logic [NT-1:0] table_rd_ack = '0, table_wr_ack = '0;
  logic [NT*EW-1:0] table_rd_data = '0;
  logic [TAW-1:0] table_addr;
  logic [EW-1:0]  table_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the software-visible registers
  logic [EW-1:0] m_entry;
  logic [31:0]   m_addr, m_cmd, m_status;

  generic_multi_table_regs #(
    .UDP_REG_SRC_WIDTH(2), .TAG(0), .REG_ADDR_WIDTH(5), .NUM_TABLES(NT),
    .TABLE_ENTRY_WIDTH(EW), .TABLE_ADDR_WIDTH(TAW), .TIMEOUT_CYCLES(TO), .REG_START_ADDR(0)
  ) dut (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .table_rd_req(table_rd_req), .table_rd_ack(table_rd_ack), .table_rd_data(table_rd_data),
    .table_wr_req(table_wr_req), .table_wr_ack(table_wr_ack),
    .table_addr(table_addr), .table_wr_data(table_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_word(input int i);
    if (i < NE)  return 32'(m_entry >> (32 * (NE - 1 - i)));
    if (i == NE) return m_addr;
    if (i == NE + 1) return m_cmd;
    return m_status;
  endfunction

  function automatic logic [EW-1:0] rand_entry();
    return EW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Present one ring request for a single cycle; returns one cycle later at the next negedge
  task automatic ring_pulse(input logic rdwr, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic ack, input logic [1:0] src);
    reg_req_in = 1'b1; reg_ack_in = ack; reg_rd_wr_L_in = rdwr;
    reg_addr_in = a; reg_data_in = d; reg_src_in = src;
    @(negedge clk);
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  task automatic pass_chk(input logic rdwr, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic ack, input logic [1:0] src);
    ring_pulse(rdwr, a, d, ack, src);
    check("pt_req",  reg_req_out, 1'b1);
    check("pt_ack",  reg_ack_out, ack);
    check("pt_rdwr", reg_rd_wr_L_out, rdwr);
    check("pt_addr", reg_addr_out, a);
    check("pt_data", reg_data_out, d);
    check("pt_src",  reg_src_out, src);
  endtask

  task automatic rd_reg(input int idx);
    logic [1:0] src;
    src = 2'($urandom());
    ring_pulse(1'b1, AW'(idx), $urandom(), 1'b0, src);
    check("rd_req",  reg_req_out, 1'b1);
    check("rd_ack",  reg_ack_out, 1'b1);
    check("rd_addr", reg_addr_out, AW'(idx));
    check("rd_src",  reg_src_out, src);
    check($sformatf("rd_word%0d", idx), reg_data_out, m_word(idx));
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] d);
    logic [1:0] src;
    int sh;
    src = 2'($urandom());
    ring_pulse(1'b0, AW'(idx), d, 1'b0, src);
    check("wr_quiet", {reg_req_out, reg_ack_out}, 2'b00);
    @(negedge clk);
    check("wr_ack",  {reg_req_out, reg_ack_out, reg_rd_wr_L_out}, 3'b110);
    check("wr_addr", reg_addr_out, AW'(idx));
    check("wr_data", reg_data_out, d);
    check("wr_src",  reg_src_out, src);
    if (idx < NE) begin
      sh = 32 * (NE - 1 - idx);
      m_entry = (m_entry & ~(EW'(32'hFFFF_FFFF) << sh)) | (EW'(d) << sh);
    end else if (idx == NE) begin
      m_addr = d;
    end
  endtask

  task automatic do_cmd(input logic op, input int sel, input int delay, input logic noack,
                        input logic [EW-1:0] rdata);
    logic [31:0]      cmdw;
    logic [1:0]       src;
    logic [NT-1:0]    exp_vec, junk, other;
    logic [NT*EW-1:0] rd_all;
    int hi;
    cmdw = {op, 23'd0, 8'(sel)};
    src  = 2'($urandom());
    ring_pulse(1'b0, AW'(NE + 1), cmdw, 1'b0, src);
    m_cmd = cmdw;
    check("cmd_quiet", {reg_req_out, reg_ack_out, table_rd_req, table_wr_req}, '0);
    @(negedge clk);
    if (sel >= NT) begin
      check("badsel_noreq", {table_rd_req, table_wr_req}, '0);
      check("badsel_early_ack", reg_ack_out, 1'b0);
      m_status = (32'(sel) << 8) | 32'h4;
      @(negedge clk);
    end else begin
      exp_vec = NT'(1) << sel;
      for (int w = 0; w < NT; w++) rd_all[w*EW +: EW] = rand_entry();
      rd_all[sel*EW +: EW] = rdata;
      table_rd_data = rd_all;
      if (!noack) begin
        for (int c = 0; c <= delay; c++) begin
          check("req_vec",   op ? table_rd_req : table_wr_req, exp_vec);
          check("other_req", op ? table_wr_req : table_rd_req, '0);
          if (c == 0) begin
            check("tbl_addr", table_addr, m_addr[TAW-1:0]);
            if (!op) check("tbl_wdata", table_wr_data, m_entry);
          end
          junk  = NT'($urandom()) & ~exp_vec;
          other = NT'($urandom());
          if (c == delay) junk = junk | exp_vec;
          if (op) begin table_rd_ack = junk;  table_wr_ack = other; end
          else    begin table_wr_ack = junk;  table_rd_ack = other; end
          @(negedge clk);
          table_rd_ack = '0; table_wr_ack = '0;
        end
        check("req_drop", {table_rd_req, table_wr_req}, '0);
        check("ack_not_yet", reg_ack_out, 1'b0);
        if (op) m_entry = rdata;
        m_status = 32'(sel) << 8;
      end else begin
        hi = 0;
        for (int c = 0; c < TO + 4; c++) begin
          if ((op ? table_rd_req : table_wr_req) != exp_vec) break;
          hi++;
          junk  = NT'($urandom()) & ~exp_vec;
          other = NT'($urandom());
          if (op) begin table_rd_ack = junk;  table_wr_ack = other; end
          else    begin table_wr_ack = junk;  table_rd_ack = other; end
          @(negedge clk);
          table_rd_ack = '0; table_wr_ack = '0;
        end
        check("timeout_len", 32'(hi), 32'(TO));
        m_status = (32'(sel) << 8) | 32'h2;
      end
      @(negedge clk);
    end
    check("cmd_ring_ack", {reg_req_out, reg_ack_out, reg_rd_wr_L_out}, 3'b110);
    check("cmd_ring_addr", reg_addr_out, AW'(NE + 1));
    check("cmd_ring_data", reg_data_out, cmdw);
    check("cmd_ring_src",  reg_src_out, src);
  endtask

  initial begin
    int r;
    m_entry = '0; m_addr = '0; m_cmd = '0; m_status = '0;
    repeat (3) @(negedge clk);
    check("rst_ring", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, '0);
    check("rst_tbl",  {table_rd_req, table_wr_req, table_addr, table_wr_data}, '0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NE + 3; i++) rd_reg(i);

    // Tag miss and tag-hit-out-of-range pass straight through
    pass_chk(1'b1, AW'(24'h1234), 32'hDEAD, 1'b0, 2'd1);
    pass_chk(1'b0, AW'(7), 32'h5A5A_0001, 1'b1, 2'd2);

    // Table write of a 72-bit entry
    wr_reg(0, 32'hAB);
    wr_reg(1, 32'h1122_3344);
    wr_reg(2, 32'h5566_7788);
    wr_reg(3, 32'd5);
    do_cmd(1'b0, 2, 3, 1'b0, '0);
    rd_reg(NE + 2);
    check("status_after_wr", m_word(NE + 2), 32'h0000_0200);

    // Table read with known data
    wr_reg(3, 32'd7);
    do_cmd(1'b1, 1, 1, 1'b0, 72'hFF_0000_0001_0000_0002);
    for (int i = 0; i < NE; i++) rd_reg(i);

    // Ack in the cycle the request rises
    do_cmd(1'b1, 0, 0, 1'b0, rand_entry());

    // Timeout leaves ENTRY untouched
    do_cmd(1'b1, 3, 0, 1'b1, rand_entry());
    for (int i = 0; i < NE + 3; i++) rd_reg(i);

    // Out-of-range select
    do_cmd(1'b0, 9, 0, 1'b0, '0);
    rd_reg(NE + 2);

    // Reset in the middle of a wait
    ring_pulse(1'b0, AW'(NE + 1), {1'b0, 23'd0, 8'd3}, 1'b0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    check("midwait_req", table_wr_req, 4'b1000);
    #2 reset = 1'b0;
    #1;
    check("midrst_tbl",  {table_rd_req, table_wr_req}, '0);
    check("midrst_ring", {reg_req_out, reg_ack_out, reg_data_out}, '0);
    @(negedge clk);
    reset = 1'b1;
    m_entry = '0; m_addr = '0; m_cmd = '0; m_status = '0;
    table_wr_ack = 4'b1000;
    @(negedge clk);
    table_wr_ack = '0;
    for (int k = 0; k < 3; k++) begin
      check("late_ack_ignored", {table_rd_req, table_wr_req, reg_req_out, reg_ack_out}, '0);
      @(negedge clk);
    end
    for (int i = 0; i < NE + 3; i++) rd_reg(i);
    wr_reg(0, $urandom());
    do_cmd(1'b0, 3, 2, 1'b0, '0);

    // Randomised traffic against the model
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        int idx;
        idx = $urandom_range(0, 4);
        if (idx == NE + 1) idx = NE + 2;
        wr_reg(idx, $urandom());
      end else if (r == 3) begin
        rd_reg($urandom_range(0, NE + 2));
      end else if (r == 4) begin
        pass_chk(1'($urandom()), AW'($urandom()) | AW'(32'h20), $urandom(), 1'($urandom()), 2'($urandom()));
      end else if (r == 5) begin
        pass_chk(1'($urandom()), AW'($urandom_range(NE + 3, 31)), $urandom(), 1'($urandom()), 2'($urandom()));
      end else begin
        do_cmd(1'($urandom()), $urandom_range(0, 5), $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0), rand_entry());
      end
    end
    for (int i = 0; i < NE + 3; i++) rd_reg(i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
